mdio_config_sequencer: RTL and testbench
========================================

MDIO_CONFIG_SEQUENCER -- requirements
Module: mdio_config_sequencer

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h00, PHY address driven on every transaction.
REQ-002 SHALL have parameter TABLE_LEN, default 32, number of config entries, 1..32.
REQ-003 SHALL have parameter VERIFY, default 1, enables the read-back pass after the write pass.
REQ-004 SHALL have parameter TIMEOUT, default 16'd4000, maximum i_clk cycles allowed per transaction.
REQ-005 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_start  input  1  one-cycle pulse that begins a configuration run.
REQ-008 SHALL have port o_rw  output  1  0 = write, 1 = read, to MDIO master.
REQ-009 SHALL have port o_phy_address  output  5  to MDIO master.
REQ-010 SHALL have port o_register_address  output  5  to MDIO master.
REQ-011 SHALL have port o_w_register_data  output  16  to MDIO master.
REQ-012 SHALL have port i_data_written_flag  input  1  one-cycle pulse, master finished a write.
REQ-013 SHALL have port i_r_register_data  input  16  read data, valid while i_data_read_flag is high.
REQ-014 SHALL have port i_data_read_flag  input  1  one-cycle pulse, master finished a read.
REQ-015 SHALL have port o_mdio_en  output  1  high only in WRITE or READ.
REQ-016 SHALL have ports o_busy, o_done, o_error  output  1 each  run status.
REQ-017 SHALL have port o_timeout  output  1  sticky flag, error was caused by a timeout.
REQ-018 SHALL have port o_mismatch_count  output  6  number of read-back mismatches.
REQ-019 SHALL have port o_fail_address  output  5  address of the first mismatch.

Function
REQ-020 SHALL hold an internal ROM with entries 0..31, in order: 1140,7949,0141,0CC2,01E1,0000,0004,2001,0000,0F00,4000,0000,0000,0000,0000,3000,0308,8110,0000,0010,0C60,0000,0000,0000,4100,0000,000A,848B,0000,0000,0000,0000 (hex).
REQ-021 SHALL use states IDLE, WRITE, READ, DONE.
REQ-022 SHALL, in IDLE, DONE or error, on i_start: clear index, o_done, o_error, o_timeout, o_mismatch_count and o_fail_address, then enter WRITE next cycle.
REQ-023 SHALL ignore i_start while o_busy = 1.
REQ-024 SHALL drive o_register_address = index and o_w_register_data = ROM[index], and hold them stable until the completion flag for that transaction.
REQ-025 SHALL, in WRITE, on i_data_written_flag: increment index and apply the new address/data on the next cycle.
REQ-026 SHALL, in WRITE, on the flag when index = TABLE_LEN-1: reset index to 0, then enter READ with o_rw = 1 if VERIFY = 1, else enter DONE.
REQ-027 SHALL, in READ, on i_data_read_flag: compare i_r_register_data with ROM[index]; on mismatch, increment o_mismatch_count (saturating at 63) and latch o_fail_address only on the first mismatch.
REQ-028 SHALL, in READ, on the flag when index = TABLE_LEN-1: enter DONE with o_rw = 0.
REQ-029 SHALL, in DONE: assert o_done = 1, set o_error = (o_mismatch_count != 0), and deassert o_busy.
REQ-030 SHALL keep o_busy = 1 in WRITE and READ only.
REQ-031 SHALL reload the per-transaction timeout counter on entry to each transaction and on each completion flag, and decrement it every cycle otherwise.
REQ-032 SHALL, when the timeout counter reaches zero: set o_timeout = 1 and o_error = 1, set o_done = 1, and enter DONE.
REQ-033 SHALL ignore a flag whose type does not match the state (e.g. a read flag in WRITE), except for timeout purposes.
REQ-034 SHALL give a completion flag and timeout expiry in the same cycle priority to the flag.

Reset
REQ-035 SHALL, while i_reset_n = 0: enter IDLE, and set index = 0, o_rw = 0, o_phy_address = PHY_ADDR, o_register_address = 0, o_w_register_data = 0, o_mdio_en = 0, all status outputs = 0 and counters = 0.
REQ-036 SHALL abandon any transaction if reset asserts mid-transaction; the next i_start restarts from index 0.

Verification
REQ-037 SHALL pass: i_start with an echoing PHY emulator -> 32 writes to addresses 0..31 with ROM data, then 32 reads; o_done = 1, o_error = 0, o_mismatch_count = 0.
REQ-038 SHALL pass: emulator returns 16'h0001 at address 5 -> o_mismatch_count = 1, o_fail_address = 5, o_error = 1.
REQ-039 SHALL pass: write flag withheld at address 3 -> o_timeout = 1 and o_error = 1 after TIMEOUT cycles, with o_register_address held at 3 until then.
REQ-040 SHALL pass: i_reset_n pulsed low at address 10 -> all outputs at reset values; a new i_start writes address 0 first.
REQ-041 SHALL pass: VERIFY = 0 -> o_done = 1 after the 32nd write flag, with no o_rw = 1 cycle.
REQ-042 SHALL pass: i_start repeated while busy -> no effect on index or status.

Source files
------------

// File: rtl/mdio_config_sequencer_if.sv
// mdio_config_sequencer_if
// Command/response bus between the configuration sequencer and an MDIO
// master (or PHY emulator).
//   o_rw                : 0 = write, 1 = read
//   o_phy_address       : PHY address of the transaction
//   o_register_address  : register address of the transaction
//   o_w_register_data   : write data (also the expected read-back value)
//   o_mdio_en           : transaction request, high while one is outstanding
//   i_data_written_flag : one-cycle pulse, master finished a write
//   i_data_read_flag    : one-cycle pulse, master finished a read
//   i_r_register_data   : read data, valid while i_data_read_flag is high
// master modport = sequencer side, slave modport = MDIO master side.
`timescale 1ns/1ps

interface mdio_config_sequencer_if;
  logic        o_rw;
  logic [4:0]  o_phy_address;
  logic [4:0]  o_register_address;
  logic [15:0] o_w_register_data;
  logic        o_mdio_en;
  logic        i_data_written_flag;
  logic        i_data_read_flag;
  logic [15:0] i_r_register_data;

  modport master (
    output o_rw, o_phy_address, o_register_address, o_w_register_data, o_mdio_en,
    input  i_data_written_flag, i_data_read_flag, i_r_register_data
  );

  modport slave (
    input  o_rw, o_phy_address, o_register_address, o_w_register_data, o_mdio_en,
    output i_data_written_flag, i_data_read_flag, i_r_register_data
  );
endinterface

// File: rtl/mdio_config_sequencer.sv
// mdio_config_sequencer
// Writes a fixed table of PHY register values over an MDIO master, then
// (optionally) reads every register back and counts mismatches. Each
// transaction is guarded by a timeout counter.
// Ports:
//   i_clk, i_reset_n    : clock, asynchronous active-low reset
//   i_start             : one-cycle pulse starting a run (ignored while busy)
//   mdio                : command/response bus to the MDIO master
//   o_busy              : run in progress (WRITE or READ)
//   o_done              : run finished (normally or by timeout)
//   o_error             : run finished with mismatches or a timeout
//   o_timeout           : sticky, the error came from a transaction timeout
//   o_mismatch_count    : read-back mismatches, saturating at 63
//   o_fail_address      : register address of the first mismatch
`timescale 1ns/1ps

module mdio_config_sequencer #(
  parameter logic [4:0]  PHY_ADDR  = 5'h00,
  parameter int          TABLE_LEN = 32,
  parameter bit          VERIFY    = 1'b1,
  parameter logic [15:0] TIMEOUT   = 16'd4000
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  mdio_config_sequencer_if.master       mdio,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic                          o_timeout,
  output logic [5:0]                    o_mismatch_count,
  output logic [4:0]                    o_fail_address
);

  localparam logic [4:0] LAST_INDEX = 5'(TABLE_LEN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  index_q;
  logic [15:0] wdata_q;
  logic [15:0] tmo_q;
  logic [5:0]  mismatch_q;
  logic [4:0]  fail_q;
  logic        done_q, error_q, timeout_q;

  logic        busy, start_accept, wr_done, rd_done, txn_done, any_flag;
  logic        last_entry, tmo_expire, rd_mismatch;
  logic [5:0]  mismatch_next;
  logic [4:0]  index_next;

  function automatic logic [15:0] rom_lookup(input logic [4:0] idx);
    logic [15:0] val;
    case (idx)
      5'd0:    val = 16'h1140;
      5'd1:    val = 16'h7949;
      5'd2:    val = 16'h0141;
      5'd3:    val = 16'h0CC2;
      5'd4:    val = 16'h01E1;
      5'd6:    val = 16'h0004;
      5'd7:    val = 16'h2001;
      5'd9:    val = 16'h0F00;
      5'd10:   val = 16'h4000;
      5'd15:   val = 16'h3000;
      5'd16:   val = 16'h0308;
      5'd17:   val = 16'h8110;
      5'd19:   val = 16'h0010;
      5'd20:   val = 16'h0C60;
      5'd24:   val = 16'h4100;
      5'd26:   val = 16'h000A;
      5'd27:   val = 16'h848B;
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

  assign busy         = (state_q == WRITE) || (state_q == READ);
  assign start_accept = i_start && !busy;
  assign wr_done      = (state_q == WRITE) && mdio.i_data_written_flag;
  assign rd_done      = (state_q == READ) && mdio.i_data_read_flag;
  assign txn_done     = wr_done || rd_done;
  // Any completion pulse, even of the wrong type, counts as bus activity
  // and reloads the watchdog; it still never advances the table.
  assign any_flag     = mdio.i_data_written_flag || mdio.i_data_read_flag;
  assign last_entry   = (index_q == LAST_INDEX);
  // A flag arriving on the final allowed cycle wins over expiry.
  assign tmo_expire   = busy && !any_flag && (tmo_q <= 16'd1);
  assign rd_mismatch  = rd_done && (mdio.i_r_register_data != wdata_q);
  assign index_next   = last_entry ? 5'd0 : index_q + 5'd1;
  assign mismatch_next = (rd_mismatch && (mismatch_q != 6'd63)) ?
                         mismatch_q + 6'd1 : mismatch_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (i_start) state_d = WRITE;
      WRITE: begin
        if (wr_done) begin
          if (last_entry) state_d = VERIFY ? READ : DONE;
        end else if (tmo_expire) begin
          state_d = DONE;
        end
      end
      READ: begin
        if (rd_done) begin
          if (last_entry) state_d = DONE;
        end else if (tmo_expire) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Table pointer, held command data, watchdog and run status. The write
  // data register always mirrors ROM[index] so it doubles as the expected
  // value during the read-back pass.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      index_q    <= 5'd0;
      wdata_q    <= 16'h0000;
      tmo_q      <= 16'd0;
      mismatch_q <= 6'd0;
      fail_q     <= 5'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (start_accept) begin
      index_q    <= 5'd0;
      wdata_q    <= rom_lookup(5'd0);
      tmo_q      <= TIMEOUT;
      mismatch_q <= 6'd0;
      fail_q     <= 5'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (busy) begin
      if (txn_done) begin
        index_q <= index_next;
        wdata_q <= rom_lookup(index_next);
        tmo_q   <= TIMEOUT;
      end else if (any_flag) begin
        tmo_q   <= TIMEOUT;
      end else if (!tmo_expire) begin
        tmo_q   <= tmo_q - 16'd1;
      end
      if (rd_mismatch) begin
        mismatch_q <= mismatch_next;
        if (mismatch_q == 6'd0) fail_q <= index_q;
      end
      if (tmo_expire) begin
        timeout_q <= 1'b1;
        error_q   <= 1'b1;
        done_q    <= 1'b1;
      end else if (state_d == DONE) begin
        done_q  <= 1'b1;
        error_q <= (mismatch_next != 6'd0);
      end
    end
  end

  assign mdio.o_rw               = (state_q == READ);
  assign mdio.o_phy_address      = PHY_ADDR;
  assign mdio.o_register_address = index_q;
  assign mdio.o_w_register_data  = wdata_q;
  assign mdio.o_mdio_en          = busy;

  assign o_busy           = busy;
  assign o_done           = done_q;
  assign o_error          = error_q;
  assign o_timeout        = timeout_q;
  assign o_mismatch_count = mismatch_q;
  assign o_fail_address   = fail_q;

endmodule

// File: tb/tb_mdio_config_sequencer.sv
// tb_mdio_config_sequencer
// Drives two sequencer instances (verify pass on / off) through a shared
// PHY emulator. Expected transactions and final status come from a table
// model of the configuration run and are checked by a monitor.
`timescale 1ns/1ps

module tb_mdio_config_sequencer;

  localparam logic [4:0]  PHY0 = 5'h11;
  localparam logic [4:0]  PHY1 = 5'h07;
  localparam int          LEN  = 32;
  localparam logic [15:0] TMO0 = 16'd4000;

  typedef struct packed {
    logic       err;
    logic       to;
    logic [5:0] mm;
    logic [4:0] fail;
  } status_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic start_r = 1'b0;
  logic sel     = 1'b0;

  logic        wr_flag = 1'b0;
  logic        rd_flag = 1'b0;
  logic [15:0] rd_data = 16'h0000;

  mdio_config_sequencer_if bus0 ();
  mdio_config_sequencer_if bus1 ();

  logic       busy0, done0, error0, timeout0, busy1, done1, error1, timeout1;
  logic [5:0] mm0, mm1;
  logic [4:0] fail0, fail1;

  assign bus0.i_data_written_flag = !sel && wr_flag;
  assign bus0.i_data_read_flag    = !sel && rd_flag;
  assign bus0.i_r_register_data   = rd_data;
  assign bus1.i_data_written_flag = sel && wr_flag;
  assign bus1.i_data_read_flag    = sel && rd_flag;
  assign bus1.i_r_register_data   = rd_data;

  mdio_config_sequencer #(.PHY_ADDR(PHY0), .TABLE_LEN(LEN), .VERIFY(1'b1), .TIMEOUT(TMO0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_r && !sel), .mdio(bus0),
    .o_busy(busy0), .o_done(done0), .o_error(error0), .o_timeout(timeout0),
    .o_mismatch_count(mm0), .o_fail_address(fail0)
  );

  mdio_config_sequencer #(.PHY_ADDR(PHY1), .TABLE_LEN(LEN), .VERIFY(1'b0), .TIMEOUT(TMO0)) dut_nv (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_r && sel), .mdio(bus1),
    .o_busy(busy1), .o_done(done1), .o_error(error1), .o_timeout(timeout1),
    .o_mismatch_count(mm1), .o_fail_address(fail1)
  );

  // View of whichever instance is currently under test.
  logic        v_rw, v_en, v_busy, v_done, v_error, v_timeout;
  logic [4:0]  v_phy, v_addr, v_fail;
  logic [15:0] v_wdata;
  logic [5:0]  v_mm;

  always_comb begin
    v_rw = bus0.o_rw; v_en = bus0.o_mdio_en; v_phy = bus0.o_phy_address;
    v_addr = bus0.o_register_address; v_wdata = bus0.o_w_register_data;
    v_busy = busy0; v_done = done0; v_error = error0; v_timeout = timeout0;
    v_mm = mm0; v_fail = fail0;
    if (sel) begin
      v_rw = bus1.o_rw; v_en = bus1.o_mdio_en; v_phy = bus1.o_phy_address;
      v_addr = bus1.o_register_address; v_wdata = bus1.o_w_register_data;
      v_busy = busy1; v_done = done1; v_error = error1; v_timeout = timeout1;
      v_mm = mm1; v_fail = fail1;
    end
  end

  logic [15:0] rom_model [LEN];
  logic        bad_mask [LEN];
  logic [15:0] bad_val [LEN];
  logic [15:0] phy_mem [LEN];
  int          stall_addr = -1;

  logic [26:0] exp_txn[$];
  status_t     exp_status[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int rw_seen_nv    = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // PHY emulator: answers each request after a random latency, echoes
  // written data on reads except for deliberately corrupted addresses,
  // and can withhold the write flag at one address.
  int lat = -1;
  always @(posedge clk) begin
    #1;
    if (wr_flag || rd_flag) begin
      wr_flag = 1'b0;
      rd_flag = 1'b0;
      rd_data = 16'($urandom);
      lat     = -1;
    end else if (!v_en) begin
      lat = -1;
    end else begin
      if (lat < 0) lat = int'($urandom_range(0, 3));
      if (lat > 0) lat--;
      else if (!v_rw) begin
        if (int'(v_addr) != stall_addr) begin
          phy_mem[v_addr] = v_wdata;
          wr_flag = 1'b1;
        end
      end else begin
        rd_data = bad_mask[v_addr] ? bad_val[v_addr] : phy_mem[v_addr];
        rd_flag = 1'b1;
      end
    end
  end

  // Monitor: checks each newly presented transaction and each completed run.
  bit new_pending = 1'b1;
  bit done_prev   = 1'b0;
  always @(negedge clk) begin
    logic [26:0] e;
    status_t     s;
    if (!v_en) new_pending = 1'b1;
    else begin
      if (new_pending) begin
        if (exp_txn.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected txn: got rw=%0b addr=%0d data=0x%0h, expected none", v_rw, v_addr, v_wdata);
        end else begin
          e = exp_txn.pop_front();
          check_output("txn {phy,rw,addr,data}", {5'd0, v_phy, v_rw, v_addr, v_wdata}, {5'd0, e});
        end
        new_pending = 1'b0;
      end
      if ((wr_flag && !v_rw) || (rd_flag && v_rw)) new_pending = 1'b1;
    end
    if (v_done && !done_prev) begin
      if (exp_status.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected done: got done=1, expected no completion");
      end else begin
        s = exp_status.pop_front();
        check_output("status error", v_error, s.err);
        check_output("status timeout", v_timeout, s.to);
        check_output("status mismatch_count", v_mm, s.mm);
        check_output("status fail_address", v_fail, s.fail);
        check_output("status busy", v_busy, 1'b0);
      end
    end
    done_prev = v_done;
    if (sel && v_rw) rw_seen_nv++;
  end

  // Reference model of one run: the write pass, optional read pass and
  // the resulting status, derived from the table and emulator settings.
  task automatic push_expected(input bit use_nv, input int stall, input int abort_at);
    logic [4:0] phy;
    status_t    s;
    int         last;
    phy  = use_nv ? PHY1 : PHY0;
    last = (stall >= 0) ? stall : (abort_at >= 0) ? abort_at : LEN - 1;
    for (int i = 0; i <= last; i++) exp_txn.push_back({phy, 1'b0, 5'(i), rom_model[i]});
    s = '0;
    if (stall >= 0) begin
      s.err = 1'b1;
      s.to  = 1'b1;
      exp_status.push_back(s);
    end else if (abort_at < 0) begin
      if (!use_nv) begin
        for (int i = 0; i < LEN; i++) begin
          exp_txn.push_back({phy, 1'b1, 5'(i), rom_model[i]});
          if (bad_mask[i] && bad_val[i] != rom_model[i]) begin
            if (s.mm == 0) s.fail = 5'(i);
            s.mm++;
          end
        end
        s.err = (s.mm != 0);
      end
      exp_status.push_back(s);
    end
  endtask

  task automatic check_reset_values(input logic [4:0] phy);
    check_output("reset rw", v_rw, 1'b0);
    check_output("reset mdio_en", v_en, 1'b0);
    check_output("reset phy_address", v_phy, phy);
    check_output("reset register_address", v_addr, 5'd0);
    check_output("reset w_register_data", v_wdata, 16'h0000);
    check_output("reset busy/done/error/timeout", {v_busy, v_done, v_error, v_timeout}, 4'b0000);
    check_output("reset mismatch_count", v_mm, 6'd0);
    check_output("reset fail_address", v_fail, 5'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int cycles = 0;
    while (!v_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      start_r = 1'b0;
      if (poke && v_busy && $urandom_range(0, 15) == 0) start_r = 1'b1;
    end
    start_r = 1'b0;
    if (!v_done) begin
      checks_total++;
      $display("[TB] FAIL done wait: got done=0 after %0d cycles, expected done=1", budget);
    end
  endtask

  task automatic wait_addr(input int addr);
    int waited = 0;
    while (!(v_en && int'(v_addr) == addr) && waited < 600) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic apply_stimulus(input bit use_nv, input int stall, input int abort_at, input bit poke);
    int held;
    stall_addr = stall;
    push_expected(use_nv, stall, abort_at);
    pulse_start();
    if (stall >= 0) begin
      wait_addr(stall);
      held = 0;
      while (v_en && int'(v_addr) == stall && held < int'(TMO0) + 50) begin
        held++;
        @(negedge clk);
      end
      check_output("timeout hold cycles", 32'(held), 32'(TMO0));
      check_output("address held at stall", v_addr, 5'(stall));
      wait_done(20, 1'b0);
    end else if (abort_at >= 0) begin
      wait_addr(abort_at);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_reset_values(use_nv ? PHY1 : PHY0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
    end else begin
      wait_done(2000, poke);
    end
    repeat (4) @(negedge clk);
    stall_addr = -1;
    check_output("txn queue drained", 32'(exp_txn.size()), 32'd0);
    check_output("status queue drained", 32'(exp_status.size()), 32'd0);
  endtask

  task automatic clear_corruption();
    for (int i = 0; i < LEN; i++) begin
      bad_mask[i] = 1'b0;
      bad_val[i]  = 16'h0000;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, k;
    rom_model = '{16'h1140, 16'h7949, 16'h0141, 16'h0CC2, 16'h01E1, 16'h0000, 16'h0004, 16'h2001,
                  16'h0000, 16'h0F00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3000,
                  16'h0308, 16'h8110, 16'h0000, 16'h0010, 16'h0C60, 16'h0000, 16'h0000, 16'h0000,
                  16'h4100, 16'h0000, 16'h000A, 16'h848B, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    clear_corruption();
    for (int i = 0; i < LEN; i++) phy_mem[i] = 16'h0000;

    repeat (3) @(negedge clk);
    check_reset_values(PHY0);
    #2 rst_n = 1'b1;

    $display("[TB] clean run with restarts attempted while busy");
    apply_stimulus(1'b0, -1, -1, 1'b1);

    $display("[TB] corrupted read-back at address 5");
    bad_mask[5] = 1'b1;
    bad_val[5]  = 16'h0001;
    apply_stimulus(1'b0, -1, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      clear_corruption();
      k = int'($urandom_range(1, 4));
      for (int j = 0; j < k; j++) begin
        a = int'($urandom_range(0, LEN - 1));
        bad_mask[a] = 1'b1;
        bad_val[a]  = 16'($urandom);
      end
      $display("[TB] random corruption run %0d", r);
      apply_stimulus(1'b0, -1, -1, 1'b1);
    end
    clear_corruption();

    $display("[TB] write flag withheld at address 3");
    apply_stimulus(1'b0, 3, -1, 1'b0);

    $display("[TB] clean run after timeout");
    apply_stimulus(1'b0, -1, -1, 1'b0);

    $display("[TB] reset pulsed at address 10, then restart");
    apply_stimulus(1'b0, -1, 10, 1'b0);
    apply_stimulus(1'b0, -1, -1, 1'b0);

    $display("[TB] instance without read-back pass");
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    check_reset_values(PHY1);
    apply_stimulus(1'b1, -1, -1, 1'b1);
    check_output("no read cycle without verify", 32'(rw_seen_nv), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
